// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the hazard_ctl pipeline sequencer.
package hazard_ctl_pkg;

    localparam int HAZ_REG_AW_DEF = 3;
    localparam int HAZ_CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } hazState_t;

    typedef struct packed {
        logic pcWrtEn;
        logic fdWrtEn;
        logic fdFlush;
        logic dxWrtEn;
        logic dxBubble;
        logic xmWrtEn;
        logic mwBubble;
        logic halted;
    } pipeCtl_t;

    // Canned control words; CTL_RUN doubles as the value driven while in reset.
    localparam pipeCtl_t CTL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam pipeCtl_t CTL_MWAIT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam pipeCtl_t CTL_HALT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_ctl_haz_match.sv
// Combinational compare of the decode instruction's sources against one producer stage.
module haz_match
    import hazard_ctl_pkg::*;
#(
    parameter int REG_AW = HAZ_REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rsD_i,
    input  logic [REG_AW-1:0] rtD_i,
    input  logic              rsUsedD_i,
    input  logic              rtUsedD_i,
    input  logic              regWrt_i,
    input  logic [REG_AW-1:0] wrtReg_i,
    output logic              hit_o
);

    logic rsHit;
    logic rtHit;

    assign rsHit = rsUsedD_i & (rsD_i == wrtReg_i);
    assign rtHit = rtUsedD_i & (rtD_i == wrtReg_i);
    assign hit_o = regWrt_i & (rsHit | rtHit);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline sequencer: flop enables/bubbles from hazards, redirects, memory waits and halt.
// HAZ_FWD_EN defined: forwarding core, stall only on load-use; undefined: stall on any X/M producer.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int REG_AW = HAZ_REG_AW_DEF,
    parameter int CNT_W  = HAZ_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              rsUsedD,
    input  logic              rtUsedD,
    input  logic              regWrtX,
    input  logic              readEnX,
    input  logic [REG_AW-1:0] wrtRegX,
    input  logic              regWrtM,
    input  logic [REG_AW-1:0] wrtRegM,
    input  logic              redirX,
    input  logic              imemStall,
    input  logic              memReqM,
    input  logic              memDoneM,
    input  logic              haltW,
    output logic              pcWrtEn,
    output logic              fdWrtEn,
    output logic              fdFlush,
    output logic              dxWrtEn,
    output logic              dxBubble,
    output logic              xmWrtEn,
    output logic              mwBubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stallCnt
);

    hazState_t        state_q, state_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    pipeCtl_t         ctl;
    logic             hitX;
    logic             hazard;
    logic             memWait;

    assign memWait = memReqM & ~memDoneM;

    haz_match #(.REG_AW(REG_AW)) uMatchX (
        .rsD_i     (rsD),
        .rtD_i     (rtD),
        .rsUsedD_i (rsUsedD),
        .rtUsedD_i (rtUsedD),
        .regWrt_i  (regWrtX),
        .wrtReg_i  (wrtRegX),
        .hit_o     (hitX)
    );

`ifdef HAZ_FWD_EN
    logic unusedM;
    assign unusedM = ^{regWrtM, wrtRegM};
    assign hazard  = readEnX & hitX;
`else
    logic hitM;
    logic unusedLd;
    assign unusedLd = readEnX;

    haz_match #(.REG_AW(REG_AW)) uMatchM (
        .rsD_i     (rsD),
        .rtD_i     (rtD),
        .rsUsedD_i (rsUsedD),
        .rtUsedD_i (rtUsedD),
        .regWrt_i  (regWrtM),
        .wrtReg_i  (wrtRegM),
        .hit_o     (hitM)
    );

    assign hazard = hitX | hitM;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // A held redirect under MWAIT is naturally acted on once memWait drops.
    always_comb begin
        state_d    = state_q;
        stallCnt_d = stallCnt_q;
        ctl        = CTL_RUN;

        case (state_q)
            HALT: begin
                ctl = CTL_HALT;
            end
            default: begin
                if (memWait) begin
                    ctl = CTL_MWAIT;
                end else if (redirX) begin
                    ctl.fdFlush  = 1'b1;
                    ctl.dxBubble = 1'b1;
                end else if (hazard) begin
                    ctl.pcWrtEn  = 1'b0;
                    ctl.fdWrtEn  = 1'b0;
                    ctl.dxBubble = 1'b1;
                end else if (imemStall) begin
                    ctl.pcWrtEn = 1'b0;
                    ctl.fdFlush = 1'b1;
                end

                if (haltW) begin
                    state_d = HALT;
                end else if (memWait) begin
                    state_d = MWAIT;
                end else begin
                    state_d = RUN;
                end
            end
        endcase

        if ((state_q != HALT) && !ctl.pcWrtEn && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end

        if (!rst) begin
            ctl = CTL_RUN;
        end
    end

    assign pcWrtEn  = ctl.pcWrtEn;
    assign fdWrtEn  = ctl.fdWrtEn;
    assign fdFlush  = ctl.fdFlush;
    assign dxWrtEn  = ctl.dxWrtEn;
    assign dxBubble = ctl.dxBubble;
    assign xmWrtEn  = ctl.xmWrtEn;
    assign mwBubble = ctl.mwBubble;
    assign halted   = ctl.halted;
    assign stallCnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: directed scenarios plus randomized traffic vs a rule-level model.
module tb_hazard_ctl;

    typedef struct packed {
        logic       rstN;
        logic [2:0] rsD;
        logic [2:0] rtD;
        logic       rsUsedD;
        logic       rtUsedD;
        logic       regWrtX;
        logic       readEnX;
        logic [2:0] wrtRegX;
        logic       regWrtM;
        logic [2:0] wrtRegM;
        logic       redirX;
        logic       imemStall;
        logic       memReqM;
        logic       memDoneM;
        logic       haltW;
    } stim_t;

    logic        clk;
    logic        rst;
    logic [2:0]  rsD, rtD, wrtRegX, wrtRegM;
    logic        rsUsedD, rtUsedD, regWrtX, readEnX, regWrtM;
    logic        redirX, imemStall, memReqM, memDoneM, haltW;
    logic        pcWrtEn, fdWrtEn, fdFlush, dxWrtEn, dxBubble, xmWrtEn, mwBubble, halted;
    logic [15:0] stallCnt;

    logic [23:0] sbQ[$];
    int          checks;
    int          errors;
    bit          mHalted;
    int          mCnt;

    hazard_ctl #(.REG_AW(3), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsUsedD   (rsUsedD),
        .rtUsedD   (rtUsedD),
        .regWrtX   (regWrtX),
        .readEnX   (readEnX),
        .wrtRegX   (wrtRegX),
        .regWrtM   (regWrtM),
        .wrtRegM   (wrtRegM),
        .redirX    (redirX),
        .imemStall (imemStall),
        .memReqM   (memReqM),
        .memDoneM  (memDoneM),
        .haltW     (haltW),
        .pcWrtEn   (pcWrtEn),
        .fdWrtEn   (fdWrtEn),
        .fdFlush   (fdFlush),
        .dxWrtEn   (dxWrtEn),
        .dxBubble  (dxBubble),
        .xmWrtEn   (xmWrtEn),
        .mwBubble  (mwBubble),
        .halted    (halted),
        .stallCnt  (stallCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idleStim();
        stim_t s;
        s      = '0;
        s.rstN = 1'b1;
        return s;
    endfunction

    // Expected outputs follow the priority list: halted > memory wait > redirect > hazard > imem stall.
    task automatic applyStimulus(input stim_t s);
        bit         hitX, hitM, haz;
        logic [7:0] e;
        @(posedge clk);
        #1;
        rst = s.rstN; rsD = s.rsD; rtD = s.rtD; rsUsedD = s.rsUsedD; rtUsedD = s.rtUsedD;
        regWrtX = s.regWrtX; readEnX = s.readEnX; wrtRegX = s.wrtRegX;
        regWrtM = s.regWrtM; wrtRegM = s.wrtRegM; redirX = s.redirX;
        imemStall = s.imemStall; memReqM = s.memReqM; memDoneM = s.memDoneM; haltW = s.haltW;

        hitX = s.regWrtX && ((s.rsUsedD && s.rsD == s.wrtRegX) || (s.rtUsedD && s.rtD == s.wrtRegX));
        hitM = s.regWrtM && ((s.rsUsedD && s.rsD == s.wrtRegM) || (s.rtUsedD && s.rtD == s.wrtRegM));
`ifdef HAZ_FWD_EN
        haz = s.readEnX && hitX;
`else
        haz = hitX || hitM;
`endif
        if (!s.rstN) begin
            mHalted = 1'b0;
            mCnt    = 0;
        end

        // Bit order: pcWrtEn fdWrtEn fdFlush dxWrtEn dxBubble xmWrtEn mwBubble halted
        if (!s.rstN)                      e = 8'b1101_0100;
        else if (mHalted)                 e = 8'b0000_0001;
        else if (s.memReqM && !s.memDoneM) e = 8'b0000_0010;
        else if (s.redirX)                e = 8'b1111_1100;
        else if (haz)                     e = 8'b0001_1100;
        else if (s.imemStall)             e = 8'b0111_0100;
        else                              e = 8'b1101_0100;

        sbQ.push_back({e, mCnt[15:0]});

        if (s.rstN) begin
            if (!mHalted && !e[7] && mCnt < 65535) mCnt++;
            if (s.haltW) mHalted = 1'b1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d at %0t",
                     name, act[23:16], act[15:0], exp[23:16], exp[15:0], $time);
        end
    endtask

    initial begin : monitor
        logic [23:0] exp;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                exp = sbQ.pop_front();
                checkOutput("cycle", {pcWrtEn, fdWrtEn, fdFlush, dxWrtEn, dxBubble,
                                      xmWrtEn, mwBubble, halted, stallCnt}, exp);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        checks = 0; errors = 0; mHalted = 1'b0; mCnt = 0;
        rst = 1'b0; rsD = '0; rtD = '0; rsUsedD = 0; rtUsedD = 0; regWrtX = 0; readEnX = 0;
        wrtRegX = '0; regWrtM = 0; wrtRegM = '0; redirX = 0; imemStall = 0;
        memReqM = 0; memDoneM = 0; haltW = 0;

        s = idleStim(); s.rstN = 1'b0;
        repeat (2) applyStimulus(s);
        repeat (2) applyStimulus(idleStim());

        $display("[TB] load-use / RAW sequence");
        s = idleStim(); s.rsD = 3'd1; s.rtD = 3'd3; s.rsUsedD = 1; s.rtUsedD = 1;
        s.regWrtX = 1; s.readEnX = 1; s.wrtRegX = 3'd1;
        applyStimulus(s);
        s.regWrtX = 0; s.readEnX = 0; s.regWrtM = 1; s.wrtRegM = 3'd1;
        applyStimulus(s);
        s.regWrtM = 0;
        applyStimulus(s);
        s = idleStim(); s.rsD = 3'd1; s.rtD = 3'd3; s.rsUsedD = 1; s.rtUsedD = 1;
        s.regWrtX = 1; s.wrtRegX = 3'd1;
        applyStimulus(s);
        s.regWrtX = 0; s.regWrtM = 1; s.wrtRegM = 3'd1;
        applyStimulus(s);
        applyStimulus(idleStim());

        $display("[TB] memory wait then done");
        s = idleStim(); s.memReqM = 1;
        repeat (3) applyStimulus(s);
        s.memDoneM = 1;
        applyStimulus(s);
        applyStimulus(idleStim());

        $display("[TB] redirect with load-use, and redirect held under wait");
        s = idleStim(); s.redirX = 1; s.rsD = 3'd2; s.rsUsedD = 1;
        s.regWrtX = 1; s.readEnX = 1; s.wrtRegX = 3'd2;
        applyStimulus(s);
        s.memReqM = 1;
        repeat (2) applyStimulus(s);
        s.memDoneM = 1;
        applyStimulus(s);
        s = idleStim(); s.imemStall = 1;
        applyStimulus(s);

        $display("[TB] halt, then reset in the middle of a memory wait");
        s = idleStim(); s.haltW = 1;
        applyStimulus(s);
        s = idleStim(); s.memReqM = 1; s.imemStall = 1;
        repeat (3) applyStimulus(s);
        s = idleStim(); s.rstN = 1'b0;
        applyStimulus(s);
        s = idleStim(); s.memReqM = 1;
        repeat (2) applyStimulus(s);
        s.rstN = 1'b0;
        repeat (2) applyStimulus(s);
        s.rstN = 1'b1; s.memDoneM = 1;
        applyStimulus(s);

        $display("[TB] stall counter saturation");
        s = idleStim(); s.rstN = 1'b0;
        applyStimulus(s);
        s = idleStim(); s.imemStall = 1;
        repeat (65541) applyStimulus(s);
        applyStimulus(idleStim());
        @(negedge clk);
        #1;
        checks++;
        if (stallCnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL saturate: got stallCnt=%h, expected ffff", stallCnt);
        end

        $display("[TB] randomized traffic");
        s = idleStim(); s.rstN = 1'b0;
        applyStimulus(s);
        for (int i = 0; i < 3000; i++) begin
            s.rstN      = ($urandom_range(0, 199) != 0);
            s.rsD       = 3'($urandom_range(0, 3));
            s.rtD       = 3'($urandom_range(0, 3));
            s.rsUsedD   = 1'($urandom_range(0, 1));
            s.rtUsedD   = 1'($urandom_range(0, 1));
            s.regWrtX   = 1'($urandom_range(0, 1));
            s.readEnX   = 1'($urandom_range(0, 1));
            s.wrtRegX   = 3'($urandom_range(0, 3));
            s.regWrtM   = 1'($urandom_range(0, 1));
            s.wrtRegM   = 3'($urandom_range(0, 3));
            s.redirX    = ($urandom_range(0, 5) == 0);
            s.imemStall = ($urandom_range(0, 4) == 0);
            s.memReqM   = ($urandom_range(0, 3) == 0);
            s.memDoneM  = 1'($urandom_range(0, 1));
            s.haltW     = ($urandom_range(0, 299) == 0);
            applyStimulus(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", sbQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
